dc_ipu_shr_stream_src: RTL and testbench

- Synthesizable valid/ready stream transmitter: the producer end of the shared IPU pipeline handshake consumed by dc_ipu_shr_pipeline_logic (in_valid/in_ready).
- On start, emits a programmable-length burst of incrementing data words with a last marker, fully honouring backpressure.
- Used as an on-chip test-pattern source ahead of IPU pipeline stages and as the stimulus driver in pipeline regressions.

---
 rtl/dc_ipu_shr_pkg.sv | 22 ++
 rtl/dc_ipu_shr_lfsr16.sv | 24 ++
 rtl/dc_ipu_shr_stream_src.sv | 102 ++++++++++
 tb/tb_dc_ipu_shr_stream_src.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_ipu_shr_pkg.sv
// Shared types and constants for the IPU stream test-pattern source and its consumers.
// Holds the FSM state encoding, LFSR constants and the common stream handshake record.
package dc_ipu_shr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Polynomial x^16+x^14+x^13+x^11+1 as a Fibonacci feedback mask on bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int STREAM_W = 8;

  typedef struct packed {
    logic                valid;
    logic                last;
    logic [STREAM_W-1:0] data;
  } stream_t;

endpackage

// File: rtl/dc_ipu_shr_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR with synchronous seed load.
// Used to pace the stream source when the gap feature is built in.
import dc_ipu_shr_pkg::*;

module dc_ipu_shr_lfsr16 (
  input  logic        clk,
  input  logic        nreset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= seed;
    end else if (enable) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/dc_ipu_shr_stream_src.sv
// Valid/ready burst source: emits len incrementing words from DATA_INIT with a last marker.
// Define DC_IPU_SHR_STREAM_SRC_GAPS_EN to insert LFSR-paced bubbles between offered words.
import dc_ipu_shr_pkg::*;

module dc_ipu_shr_stream_src #(
  parameter int               WIDTH     = 8,
  parameter int               LEN_W     = 16,
  parameter logic [WIDTH-1:0] DATA_INIT = '0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             offer;
  logic             xfer;

`ifdef DC_IPU_SHR_STREAM_SRC_GAPS_EN
  logic [15:0] lfsr_q;

  dc_ipu_shr_lfsr16 u_lfsr (
    .clk    (clk),
    .nreset (nreset),
    .enable (1'b1),
    .load   (clr),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

  assign offer = lfsr_q[0];
`else
  assign offer = 1'b1;
`endif

  assign xfer = out_valid & out_ready;
  assign busy = (state == RUN);

  // A pending word (out_valid high) is only ever retired by a transfer, clr or reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      remaining <= '0;
      out_data  <= DATA_INIT;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      remaining <= '0;
      out_data  <= DATA_INIT;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              remaining <= len;
              out_data  <= DATA_INIT;
              out_valid <= offer;
              out_last  <= (len == LEN_W'(1));
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            out_data  <= out_data + 1'b1;
            remaining <= remaining - 1'b1;
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_valid <= offer;
              out_last  <= (remaining == LEN_W'(2));
            end
          end else if (!out_valid) begin
            out_valid <= offer;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dc_ipu_shr_stream_src.sv
// Self-checking bench for dc_ipu_shr_stream_src: randomized bursts against a word-count model.
// A second instance with DATA_INIT=8'hFE shares all inputs to exercise data wrap-around.
module tb_dc_ipu_shr_stream_src;

  logic        clk;
  logic        nreset;
  logic        clr;
  logic        start;
  logic [15:0] len;
  logic        out_ready;
  logic        busy, done, out_valid, out_last;
  logic [7:0]  out_data;
  logic        busy2, done2, out_valid2, out_last2;
  logic [7:0]  out_data2;

  int tests;
  int fails;

  dc_ipu_shr_stream_src #(.WIDTH(8), .LEN_W(16), .DATA_INIT(8'h00)) dut (
    .clk(clk), .nreset(nreset), .clr(clr), .start(start), .len(len),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  dc_ipu_shr_stream_src #(.WIDTH(8), .LEN_W(16), .DATA_INIT(8'hFE)) dut2 (
    .clk(clk), .nreset(nreset), .clr(clr), .start(start), .len(len),
    .busy(busy2), .done(done2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_last(out_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst model: word k of a burst of length l is DATA_INIT+k (mod 256), last when k==l-1,
  // done one cycle after the last transfer. mode 0: ready high, 1: ready low on 2nd/4th
  // valid cycle, 2: random ready. poke issues a stray start during the burst.
  task automatic run_burst(input int l, input int mode, input bit poke,
                           output logic [255:0] pat, output int bubbles);
    int  k = 0;
    int  vcyc = 0;
    int  cyc = 0;
    int  budget = 20 * l + 40;
    bit  rdy;
    bit  stalled = 1'b0;
    pat = '0;
    bubbles = 0;
    start = 1'b1;
    len = l[15:0];
    while (k < l && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
`ifndef DC_IPU_SHR_STREAM_SRC_GAPS_EN
      tests++;
      if (out_valid !== 1'b1) begin
        fails++;
        $display("[TB] FAIL valid_in_run cyc=%0d got=%b want=1", cyc, out_valid);
      end
`endif
      if (stalled) begin
        tests++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("[TB] FAIL valid_withdrawn cyc=%0d got=%b want=1", cyc, out_valid);
        end
      end
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL busy_done_in_run cyc=%0d got=%b%b want=10", cyc, busy, done);
      end
      if (out_valid === 1'b1) begin
        if (cyc <= 256) pat[cyc-1] = 1'b1;
        tests++;
        if (out_data !== 8'(k) || out_data2 !== 8'(254 + k)) begin
          fails++;
          $display("[TB] FAIL data k=%0d got=%h/%h want=%h/%h", k, out_data, out_data2,
                   8'(k), 8'(254 + k));
        end
        tests++;
        if (out_last !== (k == l - 1)) begin
          fails++;
          $display("[TB] FAIL last k=%0d got=%b want=%b", k, out_last, (k == l - 1));
        end
      end else begin
        bubbles++;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(vcyc == 1 || vcyc == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1) vcyc++;
      out_ready = rdy;
      if (poke && cyc == 1) begin
        start = 1'b1;
        len = 16'($urandom_range(1, 20));
      end
      stalled = (out_valid === 1'b1) && !rdy;
      if (out_valid === 1'b1 && rdy) k++;
    end
    if (k < l) begin
      tests++;
      fails++;
      $display("[TB] FAIL burst_timeout got=%0d words want=%0d", k, l);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL end_of_burst got done=%b valid=%b busy=%b want 1,0,0",
               done, out_valid, busy);
    end
`ifndef DC_IPU_SHR_STREAM_SRC_GAPS_EN
    if (mode == 1) begin
      tests++;
      if (vcyc !== l + 2) begin
        fails++;
        $display("[TB] FAIL valid_cycles got=%0d want=%0d", vcyc, l + 2);
      end
    end
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== 8'h00 || out_data2 !== 8'hFE) begin
      fails++;
      $display("[TB] FAIL reset_state got v=%b l=%b b=%b d=%b data=%h/%h want 0,0,0,0,00/fe",
               out_valid, out_last, busy, done, out_data, out_data2);
    end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    start = 1'b1; len = 16'd5; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00) begin
      fails++;
      $display("[TB] FAIL async_reset got v=%b b=%b data=%h want 0,0,00", out_valid, busy, out_data);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len0();
    start = 1'b1; len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL len0_done got d=%b v=%b b=%b want 1,0,0", done, out_valid, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL len0_after got d=%b v=%b want 0,0", done, out_valid);
    end
  endtask

  task automatic test_clr();
    logic [255:0] p;
    int b;
    bit seen = 1'b0;
    start = 1'b1; len = 16'd5; out_ready = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      seen = (out_valid === 1'b1);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL clr_wait_valid got=0 want=1");
    end
    clr = 1'b1; start = 1'b1; len = 16'd3; out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr_flush got v=%b b=%b d=%b l=%b want 0,0,0,0",
               out_valid, busy, done, out_last);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL clr_after got v=%b b=%b d=%b want 0,0,0", out_valid, busy, done);
    end
    run_burst(2, 0, 1'b0, p, b);
  endtask

  task automatic test_back_to_back();
    logic [255:0] p;
    int b;
    run_burst(3, 2, 1'b0, p, b);
    run_burst(4, 2, 1'b0, p, b);
    run_burst(1, 0, 1'b0, p, b);
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_idle got d=%b b=%b want 0,0", done, busy);
    end
  endtask

  task automatic test_random();
    logic [255:0] p;
    int b;
    for (int i = 0; i < 8; i++) begin
      run_burst(int'($urandom_range(1, 12)), 2, 1'($urandom_range(0, 1)), p, b);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_fixed_bursts();
    logic [255:0] p;
    int b;
    run_burst(5, 0, 1'b0, p, b);
`ifndef DC_IPU_SHR_STREAM_SRC_GAPS_EN
    tests++;
    if (b !== 0) begin
      fails++;
      $display("[TB] FAIL no_bubbles got=%0d want=0", b);
    end
`endif
    @(negedge clk);
    run_burst(6, 1, 1'b0, p, b);
    run_burst(4, 0, 1'b0, p, b);
    run_burst(3, 0, 1'b1, p, b);
  endtask

`ifdef DC_IPU_SHR_STREAM_SRC_GAPS_EN
  task automatic test_gaps();
    logic [255:0] p1, p2;
    int b1, b2;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    run_burst(64, 0, 1'b0, p1, b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    run_burst(64, 0, 1'b0, p2, b2);
    tests++;
    if (b1 < 1) begin
      fails++;
      $display("[TB] FAIL gaps_present got=%0d want>=1", b1);
    end
    tests++;
    if (p1 !== p2) begin
      fails++;
      $display("[TB] FAIL gaps_repeat got=%h want=%h", p2, p1);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    nreset = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    len = '0;
    out_ready = 1'b0;
    test_reset();
    test_fixed_bursts();
    test_len0();
    test_clr();
    test_back_to_back();
    test_async_reset();
    test_random();
`ifdef DC_IPU_SHR_STREAM_SRC_GAPS_EN
    test_gaps();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
